pixel_deserializer: RTL and testbench
=====================================

# pixel_deserializer

Parametrised serial-to-parallel pixel deserializer for the Raspberry Pi accelerator input path. It collects a bit-serial stream qualified by `input_valid`, assembles `CHANNELS` x `CH_WIDTH`-bit pixels with selectable channel order (RGB/BGR), and buffers completed pixels in a small FIFO with a valid/ready output handshake. It sits between the Pi-facing serial receiver and the pixel-processing pipeline, so downstream stalls no longer lose pixels silently.

## Interface
- `CHANNELS`, default 3: channels per pixel, 1..4.
- `CH_WIDTH`, default 8: bits per channel, 1..16.
- `FIFO_DEPTH`, default 4: output FIFO entries, power of two, 2..16.
- `MSB_FIRST`, default 1: 1 = first received bit of a channel is its MSB; 0 = LSB.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `shift_in`, in, 1: serial data bit.
- `input_valid`, in, 1: `shift_in` is valid this cycle; deasserting it mid-pixel aborts the pixel.
- `bgr_mode`, in, 1: channel order select, sampled on the pixel's last bit.
- `pix_data`, out, `CHANNELS*CH_WIDTH`: head-of-FIFO pixel; slot s = `pix_data[s*CH_WIDTH +: CH_WIDTH]`.
- `pix_valid`, out, 1: FIFO not empty.
- `pix_ready`, in, 1: consumer accepts `pix_data` when `pix_valid && pix_ready`.
- `partial_abort`, out, 1: one-cycle pulse when a partial pixel is discarded.
- `overflow`, out, 1: sticky; a completed pixel was dropped because the FIFO was full.
- `fifo_level`, out, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- `PIX_BITS = CHANNELS*CH_WIDTH`. A bit counter `bit_cnt` runs 0..PIX_BITS-1. A shift register collects the bits.
- Each cycle with `input_valid=1`, `shift_in` is shifted in and `bit_cnt` increments. When `bit_cnt == PIX_BITS-1`, the pixel is complete and `bit_cnt` wraps to 0. Back-to-back pixels need no idle cycle.
- Each cycle with `input_valid=0`, `bit_cnt` is set to 0. If `bit_cnt != 0`, `partial_abort` pulses for one cycle and the partial data is discarded. Idle while `bit_cnt == 0` produces no pulse.
- Channel order: received channel i (0 = first) goes to slot i when `bgr_mode=0`, and to slot `CHANNELS-1-i` when `bgr_mode=1`. Bit order within a channel follows `MSB_FIRST`.
- Push: a completed pixel is written to the FIFO. If the FIFO is full and no pop occurs that cycle, the pixel is dropped and `overflow` is set. `overflow` is cleared only by `reset`.
- Simultaneous push and pop on a full FIFO: the push is accepted and the level is unchanged. Simultaneous push and pop on an empty FIFO: no pop, because `pix_valid=0`; level becomes 1.
- Pop: `pix_valid && pix_ready` advances the head. `pix_data` is held stable while `pix_valid && !pix_ready`.

## Timing
- Reset values: `bit_cnt=0`, FIFO empty, `pix_valid=0`, `pix_data=0`, `partial_abort=0`, `overflow=0`, `fifo_level=0`.
- Latency: the last bit is sampled at edge N. With an empty FIFO, `pix_valid=1` and `pix_data` are valid after edge N.
- `partial_abort` is asserted the cycle after the first `input_valid=0` cycle that follows a partial pixel.
- Reset asserted mid-pixel or with a non-empty FIFO: all state clears immediately (asynchronous). No abort pulse and no overflow result from the reset itself.
- Throughput: one pixel per PIX_BITS cycles sustained.

## Configuration
- `PIXEL_DESER_DROP_CNT_EN`, when defined:
  - adds output `drop_count[15:0]`, which counts dropped pixels and saturates at 0xFFFF;
  - `drop_count` resets to 0.
- When undefined: the port and counter are absent, and only sticky `overflow` reports drops.

## Structure
- Package `pixel_deser_pkg`:
  - default parameter constants (`CHANNELS`, `CH_WIDTH`, `FIFO_DEPTH`);
  - the `PIX_BITS` derivation function;
  - an enum for channel order (`ORDER_RGB`, `ORDER_BGR`) used for `bgr_mode`.
- One sub-module, `pixel_fifo`: a first-word-fall-through synchronous FIFO with parameters `WIDTH` and `DEPTH`, ports for push, pop, full, empty and level.

## Test plan
- Defaults, `bgr_mode=0`, stream 0x1A,0x2B,0x3C MSB-first with `pix_ready=1` -> `pix_data=0x3C2B1A`, `pix_valid` high one cycle after the 24th bit.
- Same stream with `bgr_mode=1` -> `pix_data=0x1A2B3C`. Repeat with `MSB_FIRST=0` and stream 0x58 (bits 0,0,0,1,1,0,1,0 LSB-first) -> slot 0 = 0x58.
- `input_valid` dropped after 10 bits, then a full pixel 0xFFFFFF -> `partial_abort` single pulse, the next pixel is 0xFFFFFF, and there is no corrupted pixel.
- `pix_ready=0`, 5 back-to-back pixels at `FIFO_DEPTH=4`:
  - `fifo_level` reaches 4 and the 5th pixel is dropped;
  - `overflow=1` (and `drop_count=1` with the macro);
  - draining returns pixels 1-4 in order.
- Full FIFO with `pix_ready=1` on the same cycle as a completing pixel -> pixel accepted, `fifo_level` stays 4, `overflow` stays 0.
- `reset` asserted at bit 12 with 2 pixels queued -> all outputs return to their reset values immediately; the next full pixel is assembled correctly from bit 0.

Source files
------------

// File: rtl/pixel_deser_pkg.sv
// Shared defaults, pixel size helper and channel-order encoding for the pixel deserializer.
package pixel_deser_pkg;

    localparam int unsigned DEFAULT_CHANNELS   = 3;
    localparam int unsigned DEFAULT_CH_WIDTH   = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic {
        ORDER_RGB = 1'b0,
        ORDER_BGR = 1'b1
    } ch_order_e;

    function automatic int unsigned pix_bits(input int unsigned channels,
                                             input int unsigned ch_width);
        return channels * ch_width;
    endfunction

endpackage

// File: rtl/pixel_deserializer_if.sv
// Serial-in / pixel-out bus of the deserializer. PIXEL_DESER_DROP_CNT_EN adds drop_count.
interface pixel_deserializer_if
    import pixel_deser_pkg::*;
#(
    parameter int unsigned CHANNELS   = DEFAULT_CHANNELS,
    parameter int unsigned CH_WIDTH   = DEFAULT_CH_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) ();

    localparam int unsigned PIX_BITS = pix_bits(CHANNELS, CH_WIDTH);
    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;

    logic                shift_in;
    logic                input_valid;
    logic                bgr_mode;
    logic [PIX_BITS-1:0] pix_data;
    logic                pix_valid;
    logic                pix_ready;
    logic                partial_abort;
    logic                overflow;
    logic [LVL_W-1:0]    fifo_level;
`ifdef PIXEL_DESER_DROP_CNT_EN
    logic [15:0]         drop_count;

    modport master (
        output shift_in, input_valid, bgr_mode, pix_ready,
        input  pix_data, pix_valid, partial_abort, overflow, fifo_level, drop_count
    );
    modport slave (
        input  shift_in, input_valid, bgr_mode, pix_ready,
        output pix_data, pix_valid, partial_abort, overflow, fifo_level, drop_count
    );
`else
    modport master (
        output shift_in, input_valid, bgr_mode, pix_ready,
        input  pix_data, pix_valid, partial_abort, overflow, fifo_level
    );
    modport slave (
        input  shift_in, input_valid, bgr_mode, pix_ready,
        output pix_data, pix_valid, partial_abort, overflow, fifo_level
    );
`endif

endinterface

// File: rtl/pixel_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible whenever not empty.
module pixel_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr_q];
    assign level   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_deserializer.sv
// Bit-serial to parallel pixel assembler with RGB/BGR ordering and an output FIFO.
// Define PIXEL_DESER_DROP_CNT_EN to add the saturating drop_count output.
module pixel_deserializer
    import pixel_deser_pkg::*;
#(
    parameter int unsigned CHANNELS   = DEFAULT_CHANNELS,
    parameter int unsigned CH_WIDTH   = DEFAULT_CH_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    pixel_deserializer_if.slave bus
);

    localparam int unsigned PIX_BITS = pix_bits(CHANNELS, CH_WIDTH);
    localparam int unsigned CNT_W    = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIX_BITS - 1);

    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PIX_BITS-1:0] raw_q, raw_d;
    logic [PIX_BITS-1:0] pix_rgb, pix_bgr, pixel;
    logic                abort_q, abort_d;
    logic                overflow_q, overflow_d;
    logic                pix_done, fifo_full, fifo_empty, pop, drop;
    ch_order_e           order;

    // raw_d holds bits in arrival order and already includes this cycle's bit.
    always_comb begin
        raw_d     = raw_q;
        bit_cnt_d = bit_cnt_q;
        abort_d   = 1'b0;
        pix_done  = 1'b0;
        if (bus.input_valid) begin
            raw_d[bit_cnt_q] = bus.shift_in;
            pix_done         = (bit_cnt_q == LAST_BIT);
            bit_cnt_d        = pix_done ? '0 : bit_cnt_q + CNT_W'(1);
        end else begin
            bit_cnt_d = '0;
            abort_d   = (bit_cnt_q != '0);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        for (genvar j = 0; j < CH_WIDTH; j++) begin : g_bit
            localparam int unsigned BIT_POS = MSB_FIRST ? (CH_WIDTH - 1 - j) : j;
            assign pix_rgb[i * CH_WIDTH + BIT_POS]                  = raw_d[i * CH_WIDTH + j];
            assign pix_bgr[(CHANNELS - 1 - i) * CH_WIDTH + BIT_POS] = raw_d[i * CH_WIDTH + j];
        end
    end

    assign order = ch_order_e'(bus.bgr_mode);
    assign pixel = (order == ORDER_BGR) ? pix_bgr : pix_rgb;

    assign pop        = !fifo_empty && bus.pix_ready;
    assign drop       = pix_done && fifo_full && !pop;
    assign overflow_d = overflow_q | drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            raw_q      <= '0;
            abort_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            raw_q      <= raw_d;
            abort_q    <= abort_d;
            overflow_q <= overflow_d;
        end
    end

    pixel_fifo #(
        .WIDTH (PIX_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pix_done),
        .wdata (pixel),
        .pop   (pop),
        .rdata (bus.pix_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.fifo_level)
    );

    assign bus.pix_valid     = !fifo_empty;
    assign bus.partial_abort = abort_q;
    assign bus.overflow      = overflow_q;

`ifdef PIXEL_DESER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_deserializer.sv
// Bench for pixel_deserializer: one MSB-first and one LSB-first instance fed the same stream.
module tb_pixel_deserializer;
    import pixel_deser_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic shift_in = 1'b0;
    logic input_valid = 1'b0;
    logic bgr_mode = 1'b0;
    logic pix_ready = 1'b0;

    always #5 clk = ~clk;

    pixel_deserializer_if #(.CHANNELS(3), .CH_WIDTH(8), .FIFO_DEPTH(4)) bus_a ();
    pixel_deserializer_if #(.CHANNELS(3), .CH_WIDTH(8), .FIFO_DEPTH(4)) bus_b ();

    assign bus_a.shift_in    = shift_in;
    assign bus_a.input_valid = input_valid;
    assign bus_a.bgr_mode    = bgr_mode;
    assign bus_a.pix_ready   = pix_ready;
    assign bus_b.shift_in    = shift_in;
    assign bus_b.input_valid = input_valid;
    assign bus_b.bgr_mode    = bgr_mode;
    assign bus_b.pix_ready   = pix_ready;

    pixel_deserializer #(
        .CHANNELS(3), .CH_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pixel_deserializer #(
        .CHANNELS(3), .CH_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic        bgr;
        logic [23:0] exp;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    int abort_cnt = 0;
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Channels arrive c0 first, each sent MSB-first on the wire.
    function automatic logic [23:0] model_pix(input logic [7:0] c0, input logic [7:0] c1,
                                              input logic [7:0] c2, input logic bgr,
                                              input logic msb);
        logic [7:0] a0, a1, a2;
        a0 = msb ? c0 : rev8(c0);
        a1 = msb ? c1 : rev8(c1);
        a2 = msb ? c2 : rev8(c2);
        return bgr ? {a0, a1, a2} : {a2, a1, a0};
    endfunction

    task automatic expect_pixel(input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic bgr,
                                input logic [23:0] exp_val_a);
        exp_a.push_back(exp_val_a);
        exp_b.push_back(model_pix(c0, c1, c2, bgr, 1'b0));
    endtask

    task automatic send_pixel(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic bgr, input bit rdy_last);
        logic [23:0] s;
        s = {c0, c1, c2};
        for (int k = 23; k >= 0; k--) begin
            shift_in    = s[k];
            input_valid = 1'b1;
            bgr_mode    = bgr;
            if (rdy_last && k == 0) pix_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) begin
            shift_in    = k[0];
            input_valid = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        input_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        input_valid = 1'b0;
        pix_ready   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0 && !bus_a.pix_valid && !bus_b.pix_valid)
                break;
            @(posedge clk);
            #1;
        end
        check("drain_queue_a", exp_a.size(), 0);
        check("drain_queue_b", exp_b.size(), 0);
        check("drain_level_a", bus_a.fifo_level, 0);
    endtask

    // Scoreboard: a handshake seen at negedge is the pop taken at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_a.partial_abort) abort_cnt++;
            if (bus_a.pix_valid && pix_ready) begin
                if (exp_a.size() == 0) begin
                    total_cnt++;
                    $display("FAIL pop_a: unexpected pixel 0x%0h, required none", bus_a.pix_data);
                end else begin
                    check("pop_a", bus_a.pix_data, exp_a.pop_front());
                end
            end
            if (bus_b.pix_valid && pix_ready) begin
                if (exp_b.size() == 0) begin
                    total_cnt++;
                    $display("FAIL pop_b: unexpected pixel 0x%0h, required none", bus_b.pix_data);
                end else begin
                    check("pop_b", bus_b.pix_data, exp_b.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{8'h1A, 8'h2B, 8'h3C, ORDER_RGB, 24'h3C2B1A};
        vecs[1] = '{8'h1A, 8'h2B, 8'h3C, ORDER_BGR, 24'h1A2B3C};
        vecs[2] = '{8'hFF, 8'h00, 8'h81, ORDER_RGB, 24'h8100FF};
        vecs[3] = '{8'h12, 8'h34, 8'h56, ORDER_BGR, 24'h123456};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_valid", bus_a.pix_valid, 0);
        check("rst_pix_data", bus_a.pix_data, 0);
        check("rst_abort", bus_a.partial_abort, 0);
        check("rst_overflow", bus_a.overflow, 0);
        check("rst_level", bus_a.fifo_level, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven ordering vectors, back to back.
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_pixel(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].bgr, vecs[i].exp);
            send_pixel(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].bgr, 1'b0);
            if (i == 0) begin
                check("latency_valid", bus_a.pix_valid, 1);
                check("latency_level", bus_a.fifo_level, 1);
                check("lsb_first_slot0", bus_b.pix_data[7:0], 8'h58);
            end
        end
        idle(3);
        check("no_abort_on_idle", abort_cnt, 0);

        // Abort after 10 bits, then a clean pixel.
        send_partial(10);
        input_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pulse_a", bus_a.partial_abort, 1);
        check("abort_pulse_b", bus_b.partial_abort, 1);
        @(posedge clk);
        #1;
        check("abort_single", bus_a.partial_abort, 0);
        check("abort_count", abort_cnt, 1);
        expect_pixel(8'hFF, 8'hFF, 8'hFF, 1'b0, 24'hFFFFFF);
        send_pixel(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        drain();

        // Reset mid-pixel with two pixels queued.
        pix_ready = 1'b0;
        send_pixel(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
        send_pixel(8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
        check("queued_level", bus_a.fifo_level, 2);
        send_partial(12);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", bus_a.pix_valid, 0);
        check("mid_rst_data", bus_a.pix_data, 0);
        check("mid_rst_level_a", bus_a.fifo_level, 0);
        check("mid_rst_level_b", bus_b.fifo_level, 0);
        check("mid_rst_overflow", bus_a.overflow, 0);
        check("mid_rst_abort", bus_a.partial_abort, 0);
        input_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("no_abort_after_rst", bus_a.partial_abort, 0);
        check("abort_count_after_rst", abort_cnt, 1);
        pix_ready = 1'b1;
        expect_pixel(8'hA5, 8'h5A, 8'hC3, 1'b0, 24'hC35AA5);
        send_pixel(8'hA5, 8'h5A, 8'hC3, 1'b0, 1'b0);
        drain();

        // Full FIFO: pop and push on the same edge.
        pix_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_pixel(8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k), 1'b0,
                         model_pix(8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k), 1'b0, 1'b1));
            send_pixel(8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k), 1'b0, 1'b0);
        end
        check("fill_level", bus_a.fifo_level, 4);
        expect_pixel(8'h14, 8'h24, 8'h34, 1'b0, 24'h342414);
        send_pixel(8'h14, 8'h24, 8'h34, 1'b0, 1'b1);
        check("simul_level", bus_a.fifo_level, 4);
        check("simul_overflow", bus_a.overflow, 0);
        drain();

        // Overflow: five pixels into a four-entry FIFO with the consumer stalled.
        pix_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4)
                expect_pixel(8'h40 + 8'(k), 8'h50 + 8'(k), 8'h60 + 8'(k), 1'b1,
                             model_pix(8'h40 + 8'(k), 8'h50 + 8'(k), 8'h60 + 8'(k), 1'b1, 1'b1));
            send_pixel(8'h40 + 8'(k), 8'h50 + 8'(k), 8'h60 + 8'(k), 1'b1, 1'b0);
            if (k == 3) check("ovf_pre_flag", bus_a.overflow, 0);
        end
        check("ovf_level", bus_a.fifo_level, 4);
        check("ovf_flag_a", bus_a.overflow, 1);
        check("ovf_flag_b", bus_b.overflow, 1);
`ifdef PIXEL_DESER_DROP_CNT_EN
        check("drop_count", bus_a.drop_count, 1);
`endif
        drain();
        check("ovf_sticky", bus_a.overflow, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
